mole_field_renderer: RTL

MOLE_FIELD_RENDERER -- requirements
Module: mole_field_renderer

---
 rtl/mole_field_pkg.sv | 40 ++++
 rtl/mole_field_renderer_if.sv | 26 ++
 rtl/mole_hole_fsm.sv | 118 +++++++++++
 rtl/mole_field_renderer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mole_field_pkg.sv
// Shared types and constants for the mole field renderer:
// hole FSM states, 12-bit RGB colours, hole centre table.
package mole_field_pkg;

    typedef enum logic [2:0] {
        HOLE_IDLE,
        HOLE_RISING,
        HOLE_UP,
        HOLE_FALLING,
        HOLE_WHACKED
    } hole_state_t;

    localparam int MAX_HOLES = 8;

    // Colours packed as {red, green, blue}, 4 bits each.
    localparam logic [11:0] COLOR_BG    = 12'h000;
    localparam logic [11:0] COLOR_HOLE  = 12'hFFF;
    localparam logic [11:0] COLOR_SEL   = 12'h0F0;
    localparam logic [11:0] COLOR_MOLE  = 12'hA52;
    localparam logic [11:0] COLOR_WHACK = 12'hF00;

    localparam logic [9:0] HOLE_CX [MAX_HOLES] = '{
        10'd320, 10'd220, 10'd320, 10'd420,
        10'd320, 10'd120, 10'd520, 10'd520
    };

    localparam logic [9:0] HOLE_CY [MAX_HOLES] = '{
        10'd120, 10'd220, 10'd220, 10'd220,
        10'd320, 10'd120, 10'd120, 10'd320
    };

    // Signed distance of a pixel coordinate from a centre.
    function automatic logic signed [10:0] delta(
        input logic [9:0] p,
        input logic [9:0] c
    );
        return $signed({1'b0, p}) - $signed({1'b0, c});
    endfunction

endpackage

// File: rtl/mole_field_renderer_if.sv
// Game command/response bundle: spawn and hit requests in,
// strike result pulse and per-hole occupancy out.
// master = game controller side, slave = renderer side.
interface mole_field_renderer_if;

    logic       spawn_valid;
    logic [2:0] spawn_idx;
    logic       hit_valid;
    logic [2:0] hit_idx;
    logic       hit_ack;
    logic       hit_success;
    logic [7:0] mole_up;

    modport master (
        output spawn_valid, spawn_idx,
        output hit_valid, hit_idx,
        input  hit_ack, hit_success, mole_up
    );

    modport slave (
        input  spawn_valid, spawn_idx,
        input  hit_valid, hit_idx,
        output hit_ack, hit_success, mole_up
    );

endinterface

// File: rtl/mole_hole_fsm.sv
// One hole: IDLE/RISING/UP/FALLING/WHACKED animation with height
// and frame counter. Ports: clk, rst, spawn, hit, tick in;
// state, height, hit_taken (combinational, hit accepted) out.
module mole_hole_fsm
    import mole_field_pkg::*;
#(
    parameter int MOLE_MAX_H   = 30,
    parameter int RISE_STEP    = 3,
    parameter int UP_FRAMES    = 60,
    parameter int WHACK_FRAMES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn,
    input  logic        hit,
    input  logic        tick,
    output hole_state_t state,
    output logic [7:0]  height,
    output logic        hit_taken
);

    localparam logic [7:0] MAX_H   = 8'(MOLE_MAX_H);
    localparam logic [7:0] STEP    = 8'(RISE_STEP);
    localparam logic [7:0] UP_N    = 8'(UP_FRAMES);
    localparam logic [7:0] WHACK_N = 8'(WHACK_FRAMES);

    hole_state_t state_n;
    logic [7:0]  height_n;
    logic [7:0]  cnt;
    logic [7:0]  cnt_n;
    logic [7:0]  cnt_inc;
    logic [8:0]  rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HOLE_IDLE;
            height <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            height <= height_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        height_n  = height;
        cnt_n     = cnt;
        hit_taken = 1'b0;
        cnt_inc   = cnt + 8'd1;
        rise      = {1'b0, height} + {1'b0, STEP};
        // A strike on a live mole beats a same-cycle frame tick.
        if (hit && state inside {HOLE_RISING, HOLE_UP, HOLE_FALLING}) begin
            state_n   = HOLE_WHACKED;
            cnt_n     = '0;
            hit_taken = 1'b1;
        end else begin
            unique case (state)
                HOLE_IDLE: begin
                    if (spawn) begin
                        state_n  = HOLE_RISING;
                        height_n = '0;
                        cnt_n    = '0;
                    end
                end
                HOLE_RISING: begin
                    if (tick) begin
                        if (rise >= {1'b0, MAX_H}) begin
                            height_n = MAX_H;
                            state_n  = HOLE_UP;
                            cnt_n    = '0;
                        end else begin
                            height_n = rise[7:0];
                        end
                    end
                end
                HOLE_UP: begin
                    if (tick) begin
                        if (cnt_inc == UP_N) begin
                            state_n = HOLE_FALLING;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                HOLE_FALLING: begin
                    if (tick) begin
                        if (height <= STEP) begin
                            height_n = '0;
                            state_n  = HOLE_IDLE;
                        end else begin
                            height_n = height - STEP;
                        end
                    end
                end
                HOLE_WHACKED: begin
                    if (tick) begin
                        if (cnt_inc == WHACK_N) begin
                            state_n  = HOLE_IDLE;
                            height_n = '0;
                            cnt_n    = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_n  = HOLE_IDLE;
                    height_n = '0;
                    cnt_n    = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mole_field_renderer.sv
// Whack-a-mole field: NUM_HOLES animated holes drawn as ellipses
// with rising moles, 2-cycle pixel pipeline to registered RGB.
// Ports: clk, rst, x, y, video_on, frame_tick, sel_idx, bus
// (spawn/hit in, hit_ack/hit_success/mole_up out), red/green/blue.
// Build option: MOLE_FIELD_HIGHLIGHT_EN draws hole sel_idx green.
module mole_field_renderer
    import mole_field_pkg::*;
#(
    parameter int NUM_HOLES    = 5,
    parameter int X_RADIUS     = 40,
    parameter int Y_RADIUS     = 20,
    parameter int MOLE_MAX_H   = 30,
    parameter int MOLE_HALF_W  = 12,
    parameter int RISE_STEP    = 3,
    parameter int UP_FRAMES    = 60,
    parameter int WHACK_FRAMES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       frame_tick,
    input  logic [2:0] sel_idx,
    mole_field_renderer_if.slave bus,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam logic signed [47:0] XR2  = 48'(X_RADIUS * X_RADIUS);
    localparam logic signed [47:0] YR2  = 48'(Y_RADIUS * Y_RADIUS);
    localparam logic signed [47:0] XYR2 = XR2 * YR2;
    localparam logic signed [10:0] HALF_W = 11'(MOLE_HALF_W);

    hole_state_t          state  [NUM_HOLES];
    logic [7:0]           height [NUM_HOLES];
    logic [NUM_HOLES-1:0] taken;
    logic [NUM_HOLES-1:0] in_hole;
    logic [NUM_HOLES-1:0] in_mole;
    logic [NUM_HOLES-1:0] whacked;

    logic [7:0] mole_up_c;
    logic       ack_q;
    logic       success_q;

    logic [NUM_HOLES-1:0] hole_q;
    logic [NUM_HOLES-1:0] mole_q;
    logic [NUM_HOLES-1:0] whack_q;
    logic                 von_q;
    logic [11:0]          colour_n;
    logic [11:0]          rgb_q;

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
        localparam logic [9:0] CX = HOLE_CX[g];
        localparam logic [9:0] CY = HOLE_CY[g];

        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic signed [10:0] adx;
        logic signed [47:0] dxw;
        logic signed [47:0] dyw;

        mole_hole_fsm #(
            .MOLE_MAX_H   (MOLE_MAX_H),
            .RISE_STEP    (RISE_STEP),
            .UP_FRAMES    (UP_FRAMES),
            .WHACK_FRAMES (WHACK_FRAMES)
        ) u_hole (
            .clk       (clk),
            .rst       (rst),
            .spawn     (bus.spawn_valid && bus.spawn_idx == 3'(g)),
            .hit       (bus.hit_valid && bus.hit_idx == 3'(g)),
            .tick      (frame_tick),
            .state     (state[g]),
            .height    (height[g]),
            .hit_taken (taken[g])
        );

        assign dx  = delta(x, CX);
        assign dy  = delta(y, CY);
        assign adx = dx[10] ? -dx : dx;
        assign dxw = {{37{dx[10]}}, dx};
        assign dyw = {{37{dy[10]}}, dy};

        // Exact ellipse membership, cross-multiplied to avoid division.
        assign in_hole[g] = (dxw * dxw * YR2 + dyw * dyw * XR2) <= XYR2;

        // Mole body stands on the hole centre line and grows upward.
        assign in_mole[g] = (height[g] != 8'd0)
                         && (adx <= HALF_W)
                         && (dy <= 11'sd0)
                         && (-dy <= $signed({3'b000, height[g]}));

        assign whacked[g] = (state[g] == HOLE_WHACKED);
    end

    always_comb begin
        mole_up_c = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            mole_up_c[i] = (state[i] != HOLE_IDLE);
        end
    end

    assign bus.mole_up = mole_up_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            success_q <= 1'b0;
        end else begin
            ack_q     <= bus.hit_valid;
            success_q <= |taken;
        end
    end

    assign bus.hit_ack     = ack_q;
    assign bus.hit_success = success_q;

`ifdef MOLE_FIELD_HIGHLIGHT_EN
    logic [2:0] sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_idx;
        end
    end
`endif

    // Stage 1: per-hole hit flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            hole_q  <= '0;
            mole_q  <= '0;
            whack_q <= '0;
            von_q   <= 1'b0;
        end else begin
            hole_q  <= in_hole;
            mole_q  <= in_mole;
            whack_q <= whacked;
            von_q   <= video_on;
        end
    end

    // Stage 2: priority resolve. Descending scans leave the
    // lowest index in place; any mole beats any hole.
    always_comb begin
        colour_n = COLOR_BG;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (hole_q[i]) begin
`ifdef MOLE_FIELD_HIGHLIGHT_EN
                colour_n = (sel_q == 3'(i)) ? COLOR_SEL : COLOR_HOLE;
`else
                colour_n = COLOR_HOLE;
`endif
            end
        end
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (mole_q[i]) begin
                colour_n = whack_q[i] ? COLOR_WHACK : COLOR_MOLE;
            end
        end
        if (!von_q) begin
            colour_n = COLOR_BG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= colour_n;
        end
    end

    assign {red, green, blue} = rgb_q;

endmodule
